// File: rtl/mic_level_meter.sv
// Windowed peak meter: 12-bit mic samples -> 0..15 held level plus bar mask, with timed decay.
// Latency: level/bar/level_valid update 2 clocks after the window-closing sample; no backpressure (freeze drops strobes).
module mic_level_meter #(
    parameter int unsigned WINDOW = 4000,
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned DECAY  = 2,
    parameter int unsigned CENTRE = 2048
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_en,
    input  logic [11:0] mic_in,
    input  logic        freeze,
    output logic [3:0]  level,
    output logic [15:0] bar,
    output logic        level_valid
);

    localparam logic [15:0] LP_LAST   = 16'(WINDOW - 1);
    localparam logic [7:0]  LP_DLAST  = 8'(DECAY - 1);
    localparam logic [11:0] LP_CENTRE = 12'(CENTRE);

    logic [15:0] r_win_cnt;
    logic [11:0] r_run_peak;
    logic [11:0] r_win_peak;
    logic        r_close;
    logic [3:0]  r_hold;
    logic [7:0]  r_dcnt;
    logic        r_clip;
    logic        r_upd;

    logic        w_acc;
    logic [11:0] w_peak_nxt;
    logic [11:0] w_amp_full;
    logic [10:0] w_amp;
    logic [10:0] w_shifted;
    logic [3:0]  w_new_lvl;
    logic [15:0] w_therm;

    assign w_acc = sample_en & ~freeze;
    // The first sample of a window replaces whatever peak the previous window left behind.
    assign w_peak_nxt = (r_win_cnt == 16'd0 || mic_in > r_run_peak) ? mic_in : r_run_peak;

    assign w_amp_full = (r_win_peak > LP_CENTRE) ? (r_win_peak - LP_CENTRE) : 12'd0;
    assign w_amp      = w_amp_full[10:0];
    assign w_shifted  = w_amp >> SHIFT;
    assign w_new_lvl  = (w_shifted > 11'd15) ? 4'd15 : w_shifted[3:0];
    assign w_therm    = (16'd1 << r_hold) - 16'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt  <= 16'd0;
            r_run_peak <= 12'd0;
            r_win_peak <= 12'd0;
            r_close    <= 1'b0;
        end else begin
            r_close <= 1'b0;
            if (w_acc) begin
                r_run_peak <= w_peak_nxt;
                if (r_win_cnt == LP_LAST) begin
                    r_win_peak <= w_peak_nxt;
                    r_win_cnt  <= 16'd0;
                    r_close    <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + 16'd1;
                end
            end
        end
    end

    // Hold/decay stage runs regardless of freeze so an in-flight close always lands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= 4'd0;
            r_dcnt <= 8'd0;
            r_clip <= 1'b0;
            r_upd  <= 1'b0;
        end else begin
            r_upd <= r_close;
            if (r_close) begin
                r_clip <= (r_win_peak == 12'hFFF);
                if (w_new_lvl >= r_hold) begin
                    r_hold <= w_new_lvl;
                    r_dcnt <= 8'd0;
                end else if (r_dcnt == LP_DLAST) begin
                    r_hold <= (r_hold == 4'd0) ? 4'd0 : r_hold - 4'd1;
                    r_dcnt <= 8'd0;
                end else begin
                    r_dcnt <= r_dcnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level       <= 4'd0;
            bar         <= 16'd0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= r_upd;
            if (r_upd) begin
                level <= r_hold;
                bar   <= {r_clip, w_therm[14:0]};
            end
        end
    end

endmodule

// File: tb/tb_mic_level_meter.sv
// Randomised + directed bench for mic_level_meter with a queue-based scoreboard and window-level reference model.
module tb_mic_level_meter;

    localparam int WIN = 4;
    localparam int SH  = 7;
    localparam int DEC = 2;
    localparam int CEN = 2048;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        sample_en = 1'b0;
    logic [11:0] mic_in = 12'd0;
    logic        freeze = 1'b0;
    logic [3:0]  level;
    logic [15:0] bar;
    logic        level_valid;

    mic_level_meter #(.WINDOW(WIN), .SHIFT(SH), .DECAY(DEC), .CENTRE(CEN)) dut (
        .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .mic_in(mic_in),
        .freeze(freeze), .level(level), .bar(bar), .level_valid(level_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          lvl;
        logic [15:0] bmask;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   win_q[$];
    int   m_hold = 0;
    int   m_low  = 0;
    int   cyc    = 0;
    int   checks = 0;
    int   failures = 0;
    int   mon_lvl = 0;
    logic [15:0] mon_bar = 16'd0;
    bit   mon_on = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference: a window is just the list of accepted samples; level comes from its maximum.
    task automatic model_accept(input int v);
        int pk, amp, nl;
        exp_t e;
        win_q.push_back(v);
        if (win_q.size() == WIN) begin
            pk = 0;
            foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
            win_q.delete();
            amp = (pk > CEN) ? pk - CEN : 0;
            nl  = amp / (1 << SH);
            if (nl > 15) nl = 15;
            if (nl >= m_hold) begin
                m_hold = nl;
                m_low  = 0;
            end else begin
                m_low++;
                if (m_low == DEC) begin
                    if (m_hold > 0) m_hold--;
                    m_low = 0;
                end
            end
            e.lvl   = m_hold;
            e.bmask = 16'd0;
            for (int i = 0; i < 15; i++) e.bmask[i] = (i < m_hold);
            e.bmask[15] = (pk == 4095);
            e.cyc = cyc + 3;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive(input logic en, input int v, input logic frz);
        @(posedge clock);
        #1;
        sample_en = en;
        mic_in    = 12'(v);
        freeze    = frz;
        if (en && !frz) model_accept(v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(1'b0, 0, 1'b0);
        while (sb_q.size() != 0 && n < 20) begin
            drive(1'b0, 0, 1'b0);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        drive(1'b0, 0, 1'b0);
    endtask

    task automatic window(input int a, input int b, input int c, input int d);
        drive(1'b1, a, 1'b0);
        drive(1'b1, b, 1'b0);
        drive(1'b1, c, 1'b0);
        drive(1'b1, d, 1'b0);
        drain();
    endtask

    task automatic do_reset();
        #2;
        reset_n   = 1'b0;
        sample_en = 1'b0;
        freeze    = 1'b0;
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_bar", int'(bar), 0);
        chk("reset_valid", int'(level_valid), 0);
        win_q.delete();
        sb_q.delete();
        m_hold = 0;
        m_low  = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mon_on  = 1'b1;
    endtask

    always @(negedge clock) begin
        if (!reset_n || !mon_on) begin
            mon_lvl = 0;
            mon_bar = 16'd0;
        end else if (level_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_level", int'(level), e.lvl);
                chk("sb_bar", int'(bar), int'(e.bmask));
                chk("sb_latency_cycle", cyc, e.cyc);
                mon_lvl = e.lvl;
                mon_bar = e.bmask;
            end
        end else begin
            chk("stable_between_updates", int'({level, bar}), int'({4'(mon_lvl), mon_bar}));
        end
    end

    initial begin
        do_reset();

        // Partial window discarded by a mid-window reset.
        drive(1'b1, 3000, 1'b0);
        drive(1'b1, 3000, 1'b0);
        do_reset();
        window(3000, 3000, 3000, 3000);
        chk("after_reset_level", int'(level), 7);

        window(2048, 2100, 3000, 2500);
        chk("basic_level", int'(level), 7);
        chk("basic_bar", int'(bar), 16'h007F);

        window(2048, 4095, 2100, 2000);
        chk("clip_level", int'(level), 15);
        chk("clip_bar", int'(bar), 16'hFFFF);
        window(4094, 2048, 2048, 2048);
        chk("noclip_bar", int'(bar), 16'h7FFF);

        window(2048, 2048, 2048, 2048);
        chk("decay_w1", int'(level), 15);
        window(2048, 2048, 2048, 2048);
        chk("decay_w2", int'(level), 14);
        window(2048, 2048, 2048, 2048);
        chk("decay_w3", int'(level), 14);
        window(2048, 2048, 2048, 2048);
        chk("decay_w4", int'(level), 13);
        while (m_hold >= 7) window(2048, 2048, 2048, 2048);
        window(2100, 3000, 2200, 2048);
        chk("snap_up_level", int'(level), 7);

        do_reset();
        for (int w = 0; w < 3; w++)
            window($urandom_range(0, 2048), $urandom_range(0, 2048),
                   $urandom_range(0, 2048), $urandom_range(0, 2048));
        chk("below_centre_level", int'(level), 0);
        chk("below_centre_bar", int'(bar), 0);

        do_reset();
        drive(1'b1, 2048, 1'b0);
        drive(1'b1, 2300, 1'b0);
        drive(1'b1, 4095, 1'b1);
        drive(1'b1, 4095, 1'b1);
        drive(1'b1, 4095, 1'b1);
        drive(1'b1, 2600, 1'b0);
        drive(1'b1, 2600, 1'b0);
        drain();
        chk("freeze_level", int'(level), 4);
        chk("freeze_bar", int'(bar), 16'h000F);

        for (int k = 0; k < 600; k++) begin
            int v;
            v = ($urandom_range(0, 5) == 0) ? 4095 : int'($urandom_range(0, 4095));
            drive(($urandom_range(0, 9) < 6), v, ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
